// File: rtl/scalar_mul_stream_adapter_if.sv
// Valid/ready stream bundle between producer, adapter and consumer.
// The adapter connects through the slave modport; the driving environment uses master.
interface scalar_mul_stream_adapter_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [6*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/scalar_mul_stream_adapter.sv
// Credit-based valid/ready adapter around a fixed-latency, flow-control-free scalar-multiply kernel.
// Define DFC_ZERO_BUBBLE_EN to zero the kernel operands in bubbles and enable the full-write assertion.
module scalar_mul_stream_adapter #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 8,
    parameter int DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    scalar_mul_stream_adapter_if.slave stream,
    output logic [6*WIDTH-1:0]    pipe_src,
    input  logic [WIDTH-1:0]      pipe_res,
    output logic                  busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 fifo_empty;
    logic                 fifo_full;

    logic [6*WIDTH-1:0]   pipe_src_reg;
    logic                 v0_reg;
    logic [LATENCY:1]     tag_reg;
    logic [LATENCY:1]     tag_next;
    logic [CW-1:0]        cnt_reg;
    logic [CW-1:0]        cnt_next;
    logic [AW:0]          wr_ptr_reg;
    logic [AW:0]          rd_ptr_reg;
    logic [WIDTH-1:0]     mem [DEPTH];

    // Credits cover in-flight tokens plus FIFO occupancy, so a tagged result always has a slot.
    assign stream.in_ready = reset && (cnt_reg < CW'(DEPTH));
    assign accept          = stream.in_valid && stream.in_ready;
    assign pop             = stream.out_valid && stream.out_ready;
    assign push            = tag_reg[LATENCY];

    assign fifo_empty       = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                              (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign stream.out_valid = !fifo_empty;
    assign stream.out_data  = fifo_empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign pipe_src         = pipe_src_reg;
    assign busy             = (cnt_reg != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_src_reg <= '0;
            v0_reg       <= 1'b0;
        end else begin
            v0_reg <= accept;
            if (accept) begin
                pipe_src_reg <= stream.in_data;
            end
`ifdef DFC_ZERO_BUBBLE_EN
            else begin
                pipe_src_reg <= '0;
            end
`endif
        end
    end

    always_comb begin
        tag_next    = '0;
        tag_next[1] = v0_reg;
        for (int i = 2; i <= LATENCY; i++) begin
            tag_next[i] = tag_reg[i-1];
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({accept, pop})
            2'b10:   cnt_next = cnt_reg + CW'(1);
            2'b01:   cnt_next = cnt_reg - CW'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_reg <= '0;
            cnt_reg <= '0;
        end else begin
            tag_reg <= tag_next;
            cnt_reg <= cnt_next;
        end
    end

    // Show-ahead FIFO; contents are cleared on reset so out_data never exposes stale results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr_reg[AW-1:0]] <= pipe_res;
                wr_ptr_reg              <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

`ifdef DFC_ZERO_BUBBLE_EN
    write_while_full: assert property (@(posedge clock) disable iff (!reset)
        !(push && fifo_full && !pop));
`endif

endmodule

// File: tb/tb_scalar_mul_stream_adapter.sv
// Scoreboard bench: expected dot products are queued at accept and compared at each output handshake.
// A behavioural kernel model with LATENCY register stages feeds pipe_res from pipe_src.
module tb_scalar_mul_stream_adapter;
    localparam int WIDTH   = 16;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;

    logic                clock;
    logic                reset;
    logic [6*WIDTH-1:0]  pipe_src;
    logic [WIDTH-1:0]    pipe_res;
    logic                busy;

    scalar_mul_stream_adapter_if #(.WIDTH(WIDTH)) sif ();

    scalar_mul_stream_adapter #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .stream   (sif),
        .pipe_src (pipe_src),
        .pipe_res (pipe_res),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pop_count = 0;
    int pop_cyc_q [$];
    logic [WIDTH-1:0] exp_q [$];

    function automatic logic [WIDTH-1:0] dot(input logic [6*WIDTH-1:0] d);
        logic [WIDTH-1:0] a0, a1, a2, b0, b1, b2;
        a0 = d[6*WIDTH-1 -: WIDTH];
        a1 = d[5*WIDTH-1 -: WIDTH];
        a2 = d[4*WIDTH-1 -: WIDTH];
        b0 = d[3*WIDTH-1 -: WIDTH];
        b1 = d[2*WIDTH-1 -: WIDTH];
        b2 = d[WIDTH-1   -: WIDTH];
        return WIDTH'(a0 * b0 + a1 * b1 + a2 * b2);
    endfunction

    function automatic logic [6*WIDTH-1:0] pack(input int a0, a1, a2, b0, b1, b2);
        return {WIDTH'(a0), WIDTH'(a1), WIDTH'(a2), WIDTH'(b0), WIDTH'(b1), WIDTH'(b2)};
    endfunction

    // Kernel model: runs every cycle, no reset, result LATENCY edges after the operands.
    logic [WIDTH-1:0] kstage [LATENCY];
    always @(posedge clock) begin
        kstage[0] <= dot(pipe_src);
        for (int i = 1; i < LATENCY; i++) kstage[i] <= kstage[i-1];
    end
    assign pipe_res = kstage[LATENCY-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Handshakes are sampled mid-cycle; inputs only change 1ns after the rising edge.
    always @(negedge clock) begin
        if (sif.in_valid && sif.in_ready) begin
            exp_q.push_back(dot(sif.in_data));
            $display("IN  cyc=%0d data=%h", cyc, sif.in_data);
        end
        if (sif.out_valid && sif.out_ready) begin
            $display("OUT cyc=%0d data=%0d", cyc, sif.out_data);
            pop_cyc_q.push_back(cyc);
            pop_count++;
            if (exp_q.size() == 0) check("stray_out", 32'(exp_q.size()), 32'd1);
            else check("out_data", 32'(sif.out_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [6*WIDTH-1:0] d);
        logic rdy;
        int   n;
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        n = 0;
        do begin
            @(negedge clock);
            rdy = sif.in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

    initial begin
        logic [6*WIDTH-1:0] s;
        int lat, base, c0, acc, sent;
        logic was_acc;

        reset         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(sif.out_valid), 32'd0);
        check("rst_in_ready", 32'(sif.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(sif.out_data), 32'd0);
        reset = 1'b1;
        #1;
        check("ready_after_rst", 32'(sif.in_ready), 32'd1);

        // Single set: a={1,2,3}, b={4,5,6} -> 32 after LATENCY+1 cycles.
        send(pack(1, 2, 3, 4, 5, 6));
        check("exp_single", 32'(exp_q[0]), 32'd32);
        lat = 0;
        while (!sif.out_valid && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY + 1));
        @(posedge clock);
        #1;
        check("single_valid_drop", 32'(sif.out_valid), 32'd0);
        check("single_busy", 32'(busy), 32'd0);

        // Back-to-back stream a=b={i,0,0}.
        base = pop_count;
        c0   = cyc;
        for (int i = 1; i <= 16; i++) send(pack(i, 0, 0, i, 0, 0));
        check("b2b_in_cycles", 32'(cyc - c0), 32'd16);
        wait_drain();
        check("b2b_pops", 32'(pop_count - base), 32'd16);
        if (pop_count - base == 16)
            check("b2b_no_gaps", 32'(pop_cyc_q[base+15] - pop_cyc_q[base]), 32'd15);

        // Consumer stalled: exactly DEPTH accepts, then in_ready low.
        sif.out_ready = 1'b0;
        acc = 0;
        sif.in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            sif.in_data = pack(acc + 3, 1, 0, acc + 2, 7, 0);
            @(negedge clock);
            if (sif.in_valid && sif.in_ready) acc++;
            @(posedge clock);
            #1;
        end
        check("stall_accepts", 32'(acc), 32'(DEPTH));
        check("stall_in_ready", 32'(sif.in_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        check("ready_before_pop", 32'(sif.in_ready), 32'd0);
        @(posedge clock);
        #1;
        check("ready_after_pop", 32'(sif.in_ready), 32'd1);
        wait_drain();

        // Random valid and ready: exercises pop/push at the same edge near full.
        sent = 0;
        was_acc = 1'b0;
        for (int c = 0; c < 600 && sent < 40; c++) begin
            sif.out_ready = 1'($urandom_range(0, 1));
            if (!sif.in_valid || was_acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    sif.in_valid = 1'b1;
                    sif.in_data  = pack($urandom_range(0, 255), $urandom_range(0, 255),
                                        $urandom_range(0, 255), $urandom_range(0, 255),
                                        $urandom_range(0, 255), $urandom_range(0, 255));
                end else begin
                    sif.in_valid = 1'b0;
                end
            end
            @(negedge clock);
            was_acc = sif.in_valid && sif.in_ready;
            if (was_acc) sent++;
            @(posedge clock);
            #1;
        end
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        check("rand_sent", 32'(sent), 32'd40);
        wait_drain();

        // Reset mid-stream with tokens in flight.
        sif.out_ready = 1'b0;
        send(pack(9, 9, 9, 9, 9, 9));
        send(pack(8, 8, 8, 8, 8, 8));
        send(pack(7, 7, 7, 7, 7, 7));
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 32'(sif.out_valid), 32'd0);
        check("midrst_in_ready", 32'(sif.in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pipe_src", 32'(pipe_src != '0), 32'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        sif.out_ready = 1'b1;
        repeat (LATENCY + 4) @(posedge clock);
        #1;
        check("no_stale_out", 32'(sif.out_valid), 32'd0);
        send(pack(2, 0, 0, 3, 0, 0));
        check("exp_after_rst", 32'(exp_q[0]), 32'd6);
        wait_drain();

        // Bubble behaviour of the kernel operand register.
        s = pack(5, 4, 3, 2, 1, 11);
        send(s);
        check("pipe_src_load", 32'(pipe_src == s), 32'd1);
        @(posedge clock);
        #1;
`ifdef DFC_ZERO_BUBBLE_EN
        check("pipe_src_bubble", 32'(pipe_src == '0), 32'd1);
`else
        check("pipe_src_bubble", 32'(pipe_src == s), 32'd1);
`endif
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
